// File: rtl/mdu_pkg.sv
// Shared op encodings and controller states
// for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic op_signed(
    input logic [2:0] op
  );
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Two's-complement correction of the raw
// unsigned product / quotient / remainder.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic               is_div,
  input  logic               neg_res,
  input  logic               neg_rem,
  input  logic               div_zero,
  output logic [WIDTH-1:0]   hi_n,
  output logic [WIDTH-1:0]   lo_n
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // divide-by-zero keeps the all-ones quotient unsigned
  always_comb begin
    prod = neg_res ? -acc : acc;
    quot = (neg_res && !div_zero)
         ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem
         ? -acc[2*WIDTH-1:WIDTH]
         : acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      hi_n = rem;
      lo_n = quot;
    end else begin
      hi_n = prod[2*WIDTH-1:WIDTH];
      lo_n = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/DIV unit with HI/LO regs:
// shift-add multiply, restoring divide.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e state, state_n;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;

  logic               is_mul_op;
  logic               is_div_op;
  logic               sgn;
  logic               last;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;

  logic [WIDTH-1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;

  // op decode and operand magnitudes
  always_comb begin
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    sgn       = op_signed(op);
    abs_a     = (sgn && a[WIDTH-1]) ? -a : a;
    abs_b     = (sgn && b[WIDTH-1]) ? -b : b;
    last      = (cnt == CNT_W'(WIDTH - 1));
  end

  // one shift-add or restoring-subtract step
  always_comb begin
    mul_add  = acc[0] ? mcand : '0;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
             + {1'b0, mul_add};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_sh   = {acc[2*WIDTH-1:WIDTH],
                acc[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, mcand});
    div_sub  = div_sh[WIDTH-1:0] - mcand;
    div_next = {div_ge ? div_sub
                       : div_sh[WIDTH-1:0],
                acc[WIDTH-2:0], div_ge};
  end

  // state register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // next-state logic; abort wins everywhere
  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            start && is_mul_op: state_n = ST_MUL;
            start && is_div_op: state_n = ST_DIV;
            default:            state_n = ST_IDLE;
          endcase
        end
        ST_MUL:  if (last) state_n = ST_FIX;
        ST_DIV:  if (last) state_n = ST_FIX;
        ST_FIX:  state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // output logic
  always_comb begin
    busy = (state != ST_IDLE);
  end

  // datapath, HI/LO and done pulse
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == ST_FIX) && !abort;
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (is_mul_op || is_div_op) begin
              acc      <= {{WIDTH{1'b0}}, abs_a};
              mcand    <= abs_b;
              cnt      <= '0;
              is_div   <= is_div_op;
              neg_res  <= sgn
                        && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem  <= sgn && a[WIDTH-1];
              div_zero <= (b == '0);
            end
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
          end
        end
        ST_MUL: begin
          acc <= mul_next;
          cnt <= cnt + CNT_W'(1);
        end
        ST_DIV: begin
          acc <= div_next;
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (!abort) begin
            hi <= hi_n;
            lo <= lo_n;
          end
        end
        default: ;
      endcase
    end
  end

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .acc      (acc),
    .is_div   (is_div),
    .neg_res  (neg_res),
    .neg_rem  (neg_rem),
    .div_zero (div_zero),
    .hi_n     (hi_n),
    .lo_n     (lo_n)
  );

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit
// with hand-computed HI/LO results.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         abort;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // drive a one-cycle start; returns #1
  // after the sampling edge
  task automatic launch(
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    @(negedge Clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  // wait for done, check latency/busy/result
  task automatic finish(
    input string        tag,
    input logic [W-1:0] eh,
    input logic [W-1:0] el
  );
    int n  = 0;
    int bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      @(posedge Clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_busy"}, 64'(bc), 64'd33);
    chk({tag, "_busy_at_done"},
        64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    @(posedge Clk);
    #1;
    chk({tag, "_done_pulse"},
        64'(done), 64'd0);
  endtask

  task automatic run_op(
    input string        tag,
    input logic [2:0]   o,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [W-1:0] eh,
    input logic [W-1:0] el
  );
    launch(o, x, y);
    finish(tag, eh, el);
  endtask

  initial begin
    int dn;
    Rst   = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = '0;
    b     = '0;
    abort = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;

    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_nn", 3'd0, -32'sd3, -32'sd5,
           32'd0, 32'd15);
    run_op("multu_big", 3'd1, 32'h0001_0000,
           32'h0001_0000, 32'd1, 32'd0);
    run_op("div_neg", 3'd2, -32'sd7, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 3'd2, 32'd7, -32'sd2,
           32'd1, 32'hFFFF_FFFD);
    run_op("divu", 3'd3, 32'd100, 32'd7,
           32'd2, 32'd14);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0,
           32'd7, 32'hFFFF_FFFF);
    run_op("div_zero_s", 3'd2, -32'sd9, 32'd0,
           32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd2, 32'h8000_0000,
           32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // MTHI / MTLO: single-edge load, no busy
    launch(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    launch(3'd5, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo_hi", 64'(hi), 64'h1234_5678);

    // undefined op stays idle
    launch(3'd6, 32'd5, 32'd5);
    chk("undef_busy", 64'(busy), 64'd0);
    chk("undef_hi", 64'(hi), 64'h1234_5678);

    // abort together with start in IDLE
    @(negedge Clk);
    start = 1'b1;
    abort = 1'b1;
    op    = 3'd4;
    a     = 32'h0BAD_0BAD;
    @(posedge Clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abst_hi", 64'(hi), 64'h1234_5678);
    chk("abst_busy", 64'(busy), 64'd0);

    // abort mid-MULT, start re-pulse ignored
    launch(3'd0, 32'd3, 32'd5);
    repeat (4) @(posedge Clk);
    #1;
    start = 1'b1;
    op    = 3'd4;
    a     = 32'hDEAD_BEEF;
    @(posedge Clk);
    #1;
    start = 1'b0;
    chk("repulse_busy", 64'(busy), 64'd1);
    chk("repulse_hi", 64'(hi), 64'h1234_5678);
    repeat (4) @(posedge Clk);
    #1 abort = 1'b1;
    @(posedge Clk);
    #1 abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(posedge Clk);
      #1;
    end
    chk("abort_nodone", 64'(dn), 64'd0);
    chk("abort_hi", 64'(hi), 64'h1234_5678);
    chk("abort_lo", 64'(lo), 64'hCAFE_F00D);

    // abort while in FIX drops the load
    launch(3'd1, 32'd6, 32'd7);
    repeat (32) @(posedge Clk);
    #1;
    chk("fix_busy", 64'(busy), 64'd1);
    abort = 1'b1;
    @(posedge Clk);
    #1;
    abort = 1'b0;
    chk("fixab_done", 64'(done), 64'd0);
    chk("fixab_busy", 64'(busy), 64'd0);
    chk("fixab_lo", 64'(lo), 64'hCAFE_F00D);
    @(posedge Clk);
    #1;
    chk("fixab_done2", 64'(done), 64'd0);

    // reset mid-DIV clears everything now
    launch(3'd3, 32'd100, 32'd7);
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_done", 64'(done), 64'd0);
    chk("rmid_hi", 64'(hi), 64'd0);
    chk("rmid_lo", 64'(lo), 64'd0);
    #1;
    Rst   = 1'b1;
    start = 1'b1;
    op    = 3'd1;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge Clk);
    #1 start = 1'b0;
    chk("rrel_busy", 64'(busy), 64'd1);
    finish("rrel", 32'd0, 32'd81);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width (even, 8..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), meaning iteration counter width.
REQ-003 SHALL have port Clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port a  input  WIDTH  rs operand / dividend / MTHI-MTLO source.
REQ-008 SHALL have port b  input  WIDTH  rt operand / divisor.
REQ-009 SHALL have port abort  input  1  pipeline flush; cancels any operation in flight.
REQ-010 SHALL have port busy  output  1  operation in progress; the pipeline stalls HI/LO readers on it.
REQ-011 SHALL have port done  output  1  one-cycle pulse; new HI/LO are visible.
REQ-012 SHALL have port hi  output  WIDTH  registered HI.
REQ-013 SHALL have port lo  output  WIDTH  registered LO.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, FIX.
REQ-015 SHALL, in IDLE with start=1 and op=MULT/MULTU, capture |a|,|b| (signed) or a,b (unsigned) plus the result sign, then enter MUL with counter=0.
REQ-016 SHALL, in IDLE with start=1 and op=DIV/DIVU, capture the operands likewise, then enter DIV.
REQ-017 SHALL perform one shift-add step per cycle in MUL and one restoring-subtract step per cycle in DIV, WIDTH steps in total, then enter FIX.
REQ-018 SHALL, in FIX, apply sign correction, load hi/lo, assert done for that edge's following cycle, and return to IDLE.
REQ-019 SHALL give latency of exactly WIDTH+1 cycles from the start-sampling edge to the edge loading hi/lo; busy=1 over that interval, and busy=0 in the cycle done=1.
REQ-020 SHALL, for MULT/MULTU, give {hi,lo} = full 2*WIDTH-bit product.
REQ-021 SHALL, for DIV/DIVU, give lo = quotient truncated toward zero and hi = remainder, where the remainder takes the dividend's sign.
REQ-022 SHALL, on divide by zero, give lo = all-ones and hi = a, with full latency and no exception.
REQ-023 SHALL, for signed overflow (a = -2^(WIDTH-1), b = -1), give lo = -2^(WIDTH-1) and hi = 0.
REQ-024 SHALL, for MTHI/MTLO with start=1 in IDLE, load hi (or lo) from a at that edge, with busy never asserted and done not asserted.
REQ-025 SHALL ignore start while not in IDLE, with no queuing.
REQ-026 SHALL, on abort=1, go to IDLE at the next edge from any state, leave hi/lo unchanged, and keep done=0.
REQ-027 SHALL resolve abort and start asserted together in IDLE as abort wins, with nothing started.
REQ-028 SHALL drop the FIX load when abort=1 in FIX, leaving hi/lo unchanged.
REQ-029 SHALL treat undefined op encodings with start=1 as no-ops that stay in IDLE.

Reset
REQ-030 SHALL, while Rst=0, asynchronously force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, and all datapath registers to 0.
REQ-031 SHALL treat reset mid-operation as discarding the operation, with the first start accepted on the first edge after Rst rises.

Structure
REQ-032 SHALL place op encodings and the state enum in shared package mdu_pkg, which the Controller also uses.
REQ-033 SHALL contain one sub-module mdu_sign_fix (combinational two's-complement correction of the product/quotient/remainder); the iteration logic stays in mult_div_unit.

Verification (WIDTH=32)
REQ-034 SHALL cover: MULT a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 33 cycles after start, busy high 33 cycles.
REQ-035 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-037 SHALL cover: DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 SHALL cover: MULT started, abort at cycle 10 -> busy=0 next cycle, hi/lo retain prior values, no done; start re-pulsed during busy ignored.
REQ-039 SHALL cover: MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy=0; Rst low mid-DIV -> all outputs 0 immediately.
